// File: rtl/updown_mod_counter_pkg.sv
// counter_pkg: shared constants for the up/down modulo counter.
//   DIR_UP / DIR_DOWN  - encoding of the Up input
//   WIDTH_* / MODULUS_* - legal parameter bounds
//   params_legal()     - elaboration-time legality test for WIDTH/MODULUS
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int     WIDTH_MIN   = 2;
  localparam int     WIDTH_MAX   = 32;
  localparam longint MODULUS_MIN = 2;

  // MODULUS may reach 2**32, so the check is done in 64-bit arithmetic.
  function automatic bit params_legal(input int width, input longint modulus);
    return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
           (modulus >= MODULUS_MIN) && (modulus <= (longint'(1) << width));
  endfunction

endpackage

// File: rtl/updown_mod_counter_if.sv
// updown_mod_counter_if: control/status bundle of the up/down modulo counter.
//   master: drives Data_in, Load, Count, Cin, Up, Sat; observes status.
//   slave : the counter; drives A_count, C_out, TC, Sat_hit, Load_err.
interface updown_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] Data_in;
  logic             Load;
  logic             Count;
  logic             Cin;
  logic             Up;
  logic             Sat;
  logic [WIDTH-1:0] A_count;
  logic             C_out;
  logic             TC;
  logic             Sat_hit;
  logic             Load_err;

  modport master (
    output Data_in, Load, Count, Cin, Up, Sat,
    input  A_count, C_out, TC, Sat_hit, Load_err
  );

  modport slave (
    input  Data_in, Load, Count, Cin, Up, Sat,
    output A_count, C_out, TC, Sat_hit, Load_err
  );
endinterface

// File: rtl/updown_mod_counter_next.sv
// counter_next_state: combinational next-value logic for the modulo counter.
//   cur, data_in       - current count, parallel load value
//   load, en, up, sat  - load request, step enable, direction, saturate mode
//   nxt                - next count
//   wrap / sat_evt     - this step wraps / is held at the end of range
//   load_err           - load value out of range (clamped to MODULUS-1)
//   at_end             - cur is at the terminal value for direction up
module counter_next_state
  import counter_pkg::*;
#(
  parameter int     WIDTH   = 4,
  parameter longint MODULUS = 16
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap,
  output logic             sat_evt,
  output logic             load_err,
  output logic             at_end
);

  // One spare bit keeps MODULUS-1 and the compare exact when MODULUS = 2**WIDTH.
  localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] ONE_X = (WIDTH+1)'(1);

  logic [WIDTH:0] cur_x;
  logic [WIDTH:0] data_x;
  logic [WIDTH:0] nxt_x;
  logic           unused_msb;

  always_comb begin
    cur_x    = {1'b0, cur};
    data_x   = {1'b0, data_in};
    nxt_x    = cur_x;
    wrap     = 1'b0;
    sat_evt  = 1'b0;
    load_err = 1'b0;
    at_end   = (up == DIR_UP) ? (cur_x == MAX_X) : (cur_x == '0);

    if (load) begin
      // Out-of-range loads clamp; with MODULUS = 2**WIDTH this never fires.
      if (data_x > MAX_X) begin
        nxt_x    = MAX_X;
        load_err = 1'b1;
      end else begin
        nxt_x = data_x;
      end
    end else if (en) begin
      if (at_end) begin
        if (sat) begin
          sat_evt = 1'b1;
        end else begin
          wrap  = 1'b1;
          nxt_x = (up == DIR_UP) ? '0 : MAX_X;
        end
      end else begin
        nxt_x = (up == DIR_UP) ? (cur_x + ONE_X) : (cur_x - ONE_X);
      end
    end
  end

  // nxt_x never exceeds MAX_X, so the spare bit is always zero here.
  assign nxt        = nxt_x[WIDTH-1:0];
  assign unused_msb = nxt_x[WIDTH];

endmodule

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: cascadable up/down modulo-MODULUS counter with
// wrap or saturate mode, clamped parallel load and status flags.
//   CLK   - clock, rising edge
//   Clear - synchronous active-high clear of count and flags
//   bus   - slave side of updown_mod_counter_if (controls in, status out)
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int     WIDTH   = 4,
  parameter longint MODULUS = 16
) (
  input  logic                   CLK,
  input  logic                   Clear,
  updown_mod_counter_if.slave    bus
);

  if (!params_legal(WIDTH, MODULUS)) begin : g_param_err
    $error("updown_mod_counter: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
  end

  logic [WIDTH-1:0] nxt;
  logic             en;
  logic             wrap;
  logic             sat_evt;
  logic             load_err;
  logic             at_end;

  // Load always beats a step, even when Count and Cin are both high.
  assign en = bus.Count && bus.Cin && !bus.Load;

  counter_next_state #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .cur      (bus.A_count),
    .data_in  (bus.Data_in),
    .load     (bus.Load),
    .en       (en),
    .up       (bus.Up),
    .sat      (bus.Sat),
    .nxt      (nxt),
    .wrap     (wrap),
    .sat_evt  (sat_evt),
    .load_err (load_err),
    .at_end   (at_end)
  );

  // Terminal count ignores Load so a cascaded upper stage sees a stable enable.
  assign bus.TC = bus.Count && bus.Cin && !bus.Sat && at_end;

  always_ff @(posedge CLK) begin
    if (Clear) begin
      bus.A_count  <= '0;
      bus.C_out    <= 1'b0;
      bus.Sat_hit  <= 1'b0;
      bus.Load_err <= 1'b0;
    end else begin
      bus.A_count  <= nxt;
      bus.C_out    <= wrap;
      bus.Load_err <= load_err;
      // Sticky until a load (in or out of range) or Clear.
      if (bus.Load)
        bus.Sat_hit <= 1'b0;
      else if (sat_evt)
        bus.Sat_hit <= 1'b1;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
module tb_updown_mod_counter;

  logic CLK = 1'b0;
  logic clr = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 CLK = ~CLK;

  updown_mod_counter_if #(.WIDTH(4)) bus   ();
  updown_mod_counter_if #(.WIDTH(4)) lo_if ();
  updown_mod_counter_if #(.WIDTH(4)) hi_if ();

  updown_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (.CLK(CLK), .Clear(clr), .bus(bus));
  updown_mod_counter #(.WIDTH(4), .MODULUS(16)) u_lo (.CLK(CLK), .Clear(clr), .bus(lo_if));
  updown_mod_counter #(.WIDTH(4), .MODULUS(16)) u_hi (.CLK(CLK), .Clear(clr), .bus(hi_if));

  // Upper stage is enabled by the lower stage's terminal count.
  assign hi_if.Cin = lo_if.TC;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    bus.Load = 0; bus.Count = 0; bus.Cin = 1; bus.Up = 1; bus.Sat = 0; bus.Data_in = 0;
    lo_if.Load = 0; lo_if.Count = 0; lo_if.Cin = 1; lo_if.Up = 1; lo_if.Sat = 0; lo_if.Data_in = 0;
    hi_if.Load = 0; hi_if.Count = 0; hi_if.Up = 1; hi_if.Sat = 0; hi_if.Data_in = 0;
    tick();
    n_chk++; if (bus.A_count !== 4'd0) $display("FAIL reset A_count: got %0d want 0", bus.A_count); else n_pass++;
    n_chk++; if (bus.C_out !== 1'b0) $display("FAIL reset C_out: got %b want 0", bus.C_out); else n_pass++;
    n_chk++; if (bus.Sat_hit !== 1'b0) $display("FAIL reset Sat_hit: got %b want 0", bus.Sat_hit); else n_pass++;
    n_chk++; if (bus.Load_err !== 1'b0) $display("FAIL reset Load_err: got %b want 0", bus.Load_err); else n_pass++;
    n_chk++; if (bus.TC !== 1'b0) $display("FAIL reset TC: got %b want 0", bus.TC); else n_pass++;
    clr = 1'b0;
  endtask

  task automatic test_count_up();
    logic [3:0] exp;
    bus.Count = 1; bus.Cin = 1; bus.Up = 1; bus.Sat = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp = 4'((i + 1) % 10);
      n_chk++; if (bus.A_count !== exp) $display("FAIL up[%0d] A_count: got %0d want %0d", i, bus.A_count, exp); else n_pass++;
      n_chk++; if (bus.C_out !== (exp == 4'd0)) $display("FAIL up[%0d] C_out: got %b want %b", i, bus.C_out, exp == 4'd0); else n_pass++;
      n_chk++; if (bus.TC !== (exp == 4'd9)) $display("FAIL up[%0d] TC: got %b want %b", i, bus.TC, exp == 4'd9); else n_pass++;
    end
  endtask

  task automatic test_hold();
    bus.Count = 0;
    tick();
    n_chk++; if (bus.A_count !== 4'd2) $display("FAIL hold_count0 A_count: got %0d want 2", bus.A_count); else n_pass++;
    bus.Count = 1; bus.Cin = 0;
    tick();
    n_chk++; if (bus.A_count !== 4'd2) $display("FAIL hold_cin0 A_count: got %0d want 2", bus.A_count); else n_pass++;
    n_chk++; if (bus.C_out !== 1'b0) $display("FAIL hold_cin0 C_out: got %b want 0", bus.C_out); else n_pass++;
    bus.Cin = 1; bus.Count = 0;
  endtask

  task automatic test_count_down();
    logic [3:0] exp_seq [5] = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
    bus.Load = 1; bus.Data_in = 4'd3; bus.Up = 0;
    tick();
    n_chk++; if (bus.A_count !== 4'd3) $display("FAIL down_load A_count: got %0d want 3", bus.A_count); else n_pass++;
    bus.Load = 0; bus.Count = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++; if (bus.A_count !== exp_seq[i]) $display("FAIL down[%0d] A_count: got %0d want %0d", i, bus.A_count, exp_seq[i]); else n_pass++;
      n_chk++; if (bus.C_out !== (exp_seq[i] == 4'd9)) $display("FAIL down[%0d] C_out: got %b want %b", i, bus.C_out, exp_seq[i] == 4'd9); else n_pass++;
      n_chk++; if (bus.TC !== (exp_seq[i] == 4'd0)) $display("FAIL down[%0d] TC: got %b want %b", i, bus.TC, exp_seq[i] == 4'd0); else n_pass++;
    end
    bus.Count = 0;
  endtask

  task automatic test_saturate();
    bus.Up = 1; bus.Sat = 0; bus.Count = 0; bus.Load = 1; bus.Data_in = 4'd8;
    tick();
    bus.Load = 0; bus.Sat = 1; bus.Count = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if (bus.A_count !== 4'd9) $display("FAIL sat[%0d] A_count: got %0d want 9", i, bus.A_count); else n_pass++;
      n_chk++; if (bus.Sat_hit !== (i >= 1)) $display("FAIL sat[%0d] Sat_hit: got %b want %b", i, bus.Sat_hit, i >= 1); else n_pass++;
      n_chk++; if (bus.C_out !== 1'b0) $display("FAIL sat[%0d] C_out: got %b want 0", i, bus.C_out); else n_pass++;
      n_chk++; if (bus.TC !== 1'b0) $display("FAIL sat[%0d] TC: got %b want 0", i, bus.TC); else n_pass++;
    end
    bus.Load = 1; bus.Data_in = 4'd5;
    tick();
    n_chk++; if (bus.A_count !== 4'd5) $display("FAIL sat_load A_count: got %0d want 5", bus.A_count); else n_pass++;
    n_chk++; if (bus.Sat_hit !== 1'b0) $display("FAIL sat_load Sat_hit: got %b want 0", bus.Sat_hit); else n_pass++;
    // Down saturation at 0, then switch to wrap mode on the next edge.
    bus.Count = 0; bus.Data_in = 4'd0;
    tick();
    bus.Load = 0; bus.Up = 0; bus.Count = 1;
    tick();
    n_chk++; if (bus.A_count !== 4'd0) $display("FAIL sat_down A_count: got %0d want 0", bus.A_count); else n_pass++;
    n_chk++; if (bus.Sat_hit !== 1'b1) $display("FAIL sat_down Sat_hit: got %b want 1", bus.Sat_hit); else n_pass++;
    bus.Sat = 0;
    tick();
    n_chk++; if (bus.A_count !== 4'd9) $display("FAIL sat_off A_count: got %0d want 9", bus.A_count); else n_pass++;
    n_chk++; if (bus.C_out !== 1'b1) $display("FAIL sat_off C_out: got %b want 1", bus.C_out); else n_pass++;
    n_chk++; if (bus.Sat_hit !== 1'b1) $display("FAIL sat_off sticky Sat_hit: got %b want 1", bus.Sat_hit); else n_pass++;
    bus.Count = 0; bus.Up = 1;
  endtask

  task automatic test_load();
    bus.Count = 0; bus.Sat = 0; bus.Up = 1; bus.Load = 1; bus.Data_in = 4'd12;
    tick();
    n_chk++; if (bus.A_count !== 4'd9) $display("FAIL load12 A_count: got %0d want 9", bus.A_count); else n_pass++;
    n_chk++; if (bus.Load_err !== 1'b1) $display("FAIL load12 Load_err: got %b want 1", bus.Load_err); else n_pass++;
    bus.Load = 0;
    tick();
    n_chk++; if (bus.Load_err !== 1'b0) $display("FAIL load_err_pulse Load_err: got %b want 0", bus.Load_err); else n_pass++;
    n_chk++; if (bus.A_count !== 4'd9) $display("FAIL load_err_pulse A_count: got %0d want 9", bus.A_count); else n_pass++;
    bus.Load = 1; bus.Data_in = 4'd10;
    tick();
    n_chk++; if (bus.Load_err !== 1'b1) $display("FAIL load10 Load_err: got %b want 1", bus.Load_err); else n_pass++;
    bus.Data_in = 4'd9;
    tick();
    n_chk++; if (bus.Load_err !== 1'b0) $display("FAIL load9 Load_err: got %b want 0", bus.Load_err); else n_pass++;
    n_chk++; if (bus.A_count !== 4'd9) $display("FAIL load9 A_count: got %0d want 9", bus.A_count); else n_pass++;
    // At 9 with Load and Count high: TC still flags terminal, load wins.
    bus.Count = 1; bus.Data_in = 4'd4;
    #1;
    n_chk++; if (bus.TC !== 1'b1) $display("FAIL tc_with_load TC: got %b want 1", bus.TC); else n_pass++;
    tick();
    n_chk++; if (bus.A_count !== 4'd4) $display("FAIL load_count A_count: got %0d want 4", bus.A_count); else n_pass++;
    n_chk++; if (bus.C_out !== 1'b0) $display("FAIL load_count C_out: got %b want 0", bus.C_out); else n_pass++;
    bus.Load = 0; bus.Count = 0;
  endtask

  task automatic test_clear_mid();
    bus.Load = 1; bus.Data_in = 4'd9; bus.Sat = 1; bus.Up = 1; bus.Count = 1;
    tick();
    bus.Load = 0;
    tick();
    bus.Sat = 0; bus.Up = 0;
    tick(); tick(); tick();
    n_chk++; if (bus.A_count !== 4'd6) $display("FAIL pre_clear A_count: got %0d want 6", bus.A_count); else n_pass++;
    n_chk++; if (bus.Sat_hit !== 1'b1) $display("FAIL pre_clear Sat_hit: got %b want 1", bus.Sat_hit); else n_pass++;
    clr = 1; bus.Load = 1; bus.Data_in = 4'd13;
    tick();
    n_chk++; if (bus.A_count !== 4'd0) $display("FAIL clear A_count: got %0d want 0", bus.A_count); else n_pass++;
    n_chk++; if (bus.Sat_hit !== 1'b0) $display("FAIL clear Sat_hit: got %b want 0", bus.Sat_hit); else n_pass++;
    n_chk++; if (bus.Load_err !== 1'b0) $display("FAIL clear Load_err: got %b want 0", bus.Load_err); else n_pass++;
    n_chk++; if (bus.C_out !== 1'b0) $display("FAIL clear C_out: got %b want 0", bus.C_out); else n_pass++;
    clr = 0; bus.Load = 0; bus.Up = 1;
    tick();
    n_chk++; if (bus.A_count !== 4'd1) $display("FAIL after_clear A_count: got %0d want 1", bus.A_count); else n_pass++;
    bus.Count = 0;
  endtask

  task automatic test_cascade();
    lo_if.Load = 1; lo_if.Data_in = 4'd15; hi_if.Load = 1; hi_if.Data_in = 4'd0;
    tick();
    n_chk++; if (lo_if.A_count !== 4'd15) $display("FAIL casc_load lo A_count: got %0d want 15", lo_if.A_count); else n_pass++;
    n_chk++; if (lo_if.Load_err !== 1'b0) $display("FAIL casc_load lo Load_err: got %b want 0", lo_if.Load_err); else n_pass++;
    lo_if.Load = 0; hi_if.Load = 0;
    lo_if.Count = 1; hi_if.Count = 1;
    #1;
    n_chk++; if (lo_if.TC !== 1'b1) $display("FAIL casc lo TC: got %b want 1", lo_if.TC); else n_pass++;
    tick();
    n_chk++; if (lo_if.A_count !== 4'd0) $display("FAIL casc lo A_count: got %0d want 0", lo_if.A_count); else n_pass++;
    n_chk++; if (hi_if.A_count !== 4'd1) $display("FAIL casc hi A_count: got %0d want 1", hi_if.A_count); else n_pass++;
    n_chk++; if (lo_if.C_out !== 1'b1) $display("FAIL casc lo C_out: got %b want 1", lo_if.C_out); else n_pass++;
    n_chk++; if (hi_if.C_out !== 1'b0) $display("FAIL casc hi C_out: got %b want 0", hi_if.C_out); else n_pass++;
    tick();
    n_chk++; if (lo_if.A_count !== 4'd1) $display("FAIL casc2 lo A_count: got %0d want 1", lo_if.A_count); else n_pass++;
    n_chk++; if (hi_if.A_count !== 4'd1) $display("FAIL casc2 hi A_count: got %0d want 1", hi_if.A_count); else n_pass++;
    lo_if.Count = 0; hi_if.Count = 0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_hold();
    test_count_down();
    test_saturate();
    test_load();
    test_clear_mid();
    test_cascade();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits, legal range 2..32.
REQ-002 SHALL have parameter MODULUS, default 16: count range 0..MODULUS-1, legal range 2..2**WIDTH.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port CLK, input, 1 bit: clock, rising-edge active.
REQ-005 SHALL have port Clear, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port Data_in, input, WIDTH bits: parallel load value.
REQ-007 SHALL have port Load, input, 1 bit: parallel load request.
REQ-008 SHALL have port Count, input, 1 bit: count enable.
REQ-009 SHALL have port Cin, input, 1 bit: cascade enable from the lower stage; tie to 1 when not cascaded.
REQ-010 SHALL have port Up, input, 1 bit: direction, 1 = increment, 0 = decrement.
REQ-011 SHALL have port Sat, input, 1 bit: mode, 1 = saturate at the end of range, 0 = wrap around.
REQ-012 SHALL have port A_count, output, WIDTH bits: registered count.
REQ-013 SHALL have port C_out, output, 1 bit: registered one-cycle wrap pulse.
REQ-014 SHALL have port TC, output, 1 bit: combinational terminal count, for cascading.
REQ-015 SHALL have port Sat_hit, output, 1 bit: registered sticky saturation flag.
REQ-016 SHALL have port Load_err, output, 1 bit: registered one-cycle out-of-range load pulse.

Function
REQ-017 Priority per rising CLK edge SHALL be: Clear, then Load, then step (Count && Cin), then hold.
REQ-018 Step condition SHALL be: en = Count && Cin && !Load.
REQ-019 Up step: A_count < MODULUS-1 -> A_count+1; at MODULUS-1 -> 0 when Sat=0, hold when Sat=1.
REQ-020 Down step: A_count > 0 -> A_count-1; at 0 -> MODULUS-1 when Sat=0, hold when Sat=1.
REQ-021 Next-value arithmetic SHALL use WIDTH+1 bits internally; no truncation artefacts when MODULUS = 2**WIDTH.
REQ-022 C_out SHALL be 1 for exactly the one cycle after an edge on which a wrap occurred (either direction, Sat=0); 0 otherwise, including cycles with Count held high and no wrap.
REQ-023 TC SHALL be Count && Cin && Sat==0 && (Up ? A_count==MODULUS-1 : A_count==0); it is independent of Load.
REQ-024 Saturate event: Sat=1 with en at the terminal value -> A_count holds and Sat_hit is set to 1.
REQ-025 Sat_hit SHALL remain set until Clear or an accepted Load; Load clears it even when the load is out of range.
REQ-026 Load with Data_in < MODULUS SHALL set A_count = Data_in; Load_err = 0.
REQ-027 Load with Data_in >= MODULUS SHALL set A_count = MODULUS-1 (clamp) and pulse Load_err for one cycle.
REQ-028 Load and Count asserted together: load wins, no step, C_out = 0.
REQ-029 Up and Sat changes SHALL take effect on the next edge; there is no internal state beyond A_count and the flags.
REQ-030 When MODULUS = 2**WIDTH, Load_err SHALL never assert.

Reset
REQ-031 Clear=1 at a rising edge SHALL set A_count=0, C_out=0, Sat_hit=0, Load_err=0, overriding Load and Count.
REQ-032 Clear mid-count SHALL abort immediately; counting resumes from 0 on the first edge with Clear=0 and en=1.
REQ-033 Clear SHALL NOT act asynchronously; outputs change only on CLK rising edges, except combinational TC.

Structure
REQ-034 A shared package counter_pkg SHALL hold the direction encoding constants (DIR_UP=1, DIR_DOWN=0) and the parameter-legality check constants.
REQ-035 Next-value logic (next count, wrap, saturate, clamp) SHALL be a combinational sub-module counter_next_state; the top holds registers and the flags.
REQ-036 Illegal WIDTH/MODULUS SHALL be flagged by an elaboration-time check.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-037 Scenario: Clear=1 for 1 edge, then Count=1, Cin=1, Up=1, Sat=0 for 12 edges -> A_count 1..9,0,1,2; C_out high only in the cycle after 9->0; TC=1 while A_count=9.
REQ-038 Scenario: Load 3, then Up=0 for 5 edges -> 2,1,0,9,8; C_out pulses after 0->9.
REQ-039 Scenario: Sat=1, Up=1 from 8 for 4 edges -> 9,9,9,9; Sat_hit=1 from the second 9 onward; C_out never asserts; Load 5 -> A_count=5, Sat_hit=0.
REQ-040 Scenario: Load=1 with Data_in=12 -> A_count=9, Load_err=1 for one cycle; Load and Count together with Data_in=4 -> A_count=4, no step.
REQ-041 Scenario: Clear=1 asserted mid-count at A_count=6 together with Load=1 -> next A_count=0, all flags 0.
REQ-042 Scenario: two instances, MODULUS=16, low TC drives high Cin, start at 0x0F -> one edge gives low=0, high=1; WIDTH=4, MODULUS=16, load 15 then step -> 0, C_out=1.
